rv_muldiv_unit: RTL and testbench

- Iterative RV32M-style multiply/divide unit for the pipelined RV32i core.
- Sits in the EXE stage beside the ALU. EXE issues a one-cycle start; the unit holds the pipeline through stall_req until the result is ready.
- Result goes back with the destination-register tag so EXE_MEM can capture it and write it back.
- Width and tag width are parametrised so the unit generalises beyond the fixed-32-bit, single-cycle ALU path.

---
 rtl/rv_muldiv_unit.sv | 190 +++++++++++++++++++
 tb/tb_rv_muldiv_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EXE stage; holds the pipeline via stall_req.
// Optional MULDIV_FAST_MUL_EN: multiplies use one combinational multiplier (PREP -> FIN).
module rv_muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             kill,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StPrep, StCalc, StFin} state_e;

  state_e           state_q;
  logic [2:0]       op_q;
  logic [XLEN-1:0]  a_q, b_q;
  logic [XLEN-1:0]  acc_q, lo_q, opb_q, spec_q;
  logic [CntW-1:0]  cnt_q;
  logic             neg_q, special_q, done_q;
  logic [XLEN-1:0]  result_q;
  logic [TAG_W-1:0] tag_q, tag_out_q;

  // Operand preparation
  logic            is_div, a_signed, b_signed, a_neg, b_neg;
  logic            div_zero, div_ovf, prep_neg;
  logic [XLEN-1:0] mag_a, mag_b, spec_val;

  always_comb begin
    is_div   = op_q[2];
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op_q)
      3'd1, 3'd4, 3'd6: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'd2:    a_signed = 1'b1;
      default: ;
    endcase
    a_neg    = a_signed & a_q[XLEN-1];
    b_neg    = b_signed & b_q[XLEN-1];
    mag_a    = a_neg ? -a_q : a_q;
    mag_b    = b_neg ? -b_q : b_q;
    div_zero = is_div & (b_q == '0);
    div_ovf  = is_div & b_signed & (a_q == MinVal) & (b_q == '1);
    // Remainder follows the dividend; products and quotients follow sign(a) ^ sign(b).
    prep_neg = (is_div & op_q[1]) ? a_neg : (a_neg ^ b_neg);
    if (div_zero) begin
      spec_val = op_q[1] ? a_q : '1;
    end else begin
      spec_val = op_q[1] ? '0 : MinVal;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

  // One iteration of shift-add multiply or restoring divide
  logic [XLEN:0]   mul_add, div_rsh, div_diff;
  logic            div_ge;
  logic [XLEN-1:0] calc_acc, calc_lo;

  always_comb begin
    mul_add  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    div_rsh  = {acc_q, lo_q[XLEN-1]};
    div_diff = div_rsh - {1'b0, opb_q};
    div_ge   = ~div_diff[XLEN];
    if (is_div) begin
      calc_acc = div_ge ? div_diff[XLEN-1:0] : div_rsh[XLEN-1:0];
      calc_lo  = {lo_q[XLEN-2:0], div_ge};
    end else begin
      calc_acc = mul_add[XLEN:1];
      calc_lo  = {mul_add[0], lo_q[XLEN-1:1]};
    end
  end

  // Sign correction and half/quotient/remainder selection
  logic [2*XLEN-1:0] prod_full, prod_sgn;
  logic [XLEN-1:0]   quo_sgn, rem_sgn, fin_res;

  always_comb begin
    prod_full = {acc_q, lo_q};
    prod_sgn  = neg_q ? -prod_full : prod_full;
    quo_sgn   = neg_q ? -lo_q : lo_q;
    rem_sgn   = neg_q ? -acc_q : acc_q;
    if (special_q) begin
      fin_res = spec_q;
    end else if (is_div) begin
      fin_res = op_q[1] ? rem_sgn : quo_sgn;
    end else if (op_q[1:0] == 2'd0) begin
      fin_res = prod_sgn[XLEN-1:0];
    end else begin
      fin_res = prod_sgn[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      opb_q     <= '0;
      spec_q    <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      tag_q     <= '0;
      tag_out_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (kill && (state_q != StIdle)) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start && !kill) begin
              op_q    <= op;
              a_q     <= a;
              b_q     <= b;
              tag_q   <= tag_in;
              state_q <= StPrep;
            end
          end
          StPrep: begin
            neg_q     <= prep_neg;
            special_q <= div_zero | div_ovf;
            spec_q    <= spec_val;
            acc_q     <= '0;
            lo_q      <= mag_a;
            opb_q     <= mag_b;
            cnt_q     <= CntW'(XLEN - 1);
            if (div_zero || div_ovf) begin
              state_q <= StFin;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!is_div) begin
              acc_q   <= fast_prod[2*XLEN-1:XLEN];
              lo_q    <= fast_prod[XLEN-1:0];
              state_q <= StFin;
`endif
            end else begin
              state_q <= StCalc;
            end
          end
          StCalc: begin
            acc_q <= calc_acc;
            lo_q  <= calc_lo;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
              state_q <= StFin;
            end
          end
          StFin: begin
            result_q  <= fin_res;
            tag_out_q <= tag_q;
            done_q    <= 1'b1;
            state_q   <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign busy      = (state_q != StIdle);
  assign stall_req = busy | (start & ~kill);
  assign done      = done_q;
  assign result    = result_q;
  assign tag_out   = tag_out_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Self-checking bench for rv_muldiv_unit: directed vector table, multi-cycle corner
// sequences and randomized operations against an arithmetic reference model.
module tb_rv_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [4:0]  tag_in;
  logic        kill;
  logic        busy, stall_req, done;
  logic [31:0] result;
  logic [4:0]  tag_out;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] last_res;
  logic [4:0]  last_tag;

  rv_muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .tag_in    (tag_in),
    .kill      (kill),
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done),
    .result    (result),
    .tag_out   (tag_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Arithmetic reference computed directly from the RV32M rules.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint      sx, sy, uy;
    logic [63:0] p, ux64, uy64;
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    uy   = longint'({32'd0, y});
    ux64 = {32'd0, x};
    uy64 = {32'd0, y};
    case (o)
      3'd0: begin p = 64'(sx * sy); return p[31:0]; end
      3'd1: begin p = 64'(sx * sy); return p[63:32]; end
      3'd2: begin p = 64'(sx * uy); return p[63:32]; end
      3'd3: begin p = ux64 * uy64;  return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sx / sy);
      end
      3'd5: begin
        if (y == 0) return 32'hFFFF_FFFF;
        return x / y;
      end
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sx % sy);
      end
      default: begin
        if (y == 0) return x;
        return x % y;
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] x,
                                 input logic [31:0] y);
    if (o[2] && (y == 0)) return 2;
    if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 2;
`ifdef MULDIV_FAST_MUL_EN
    if (!o[2]) return 2;
`endif
    return 34;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] t, input string nm);
    op = o; a = x; b = y; tag_in = t; start = 1'b1;
    #1;
    chk({nm, " stall_at_start"}, {31'd0, stall_req}, 32'd1);
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit held);
    cyc  = 0;
    held = 1'b1;
    while (!done && cyc < 200) begin
      if (!busy || !stall_req) held = 1'b0;
      step();
      cyc++;
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] t, input logic [31:0] exp, input string nm);
    int cyc;
    bit held;
    issue(o, x, y, t, nm);
    wait_done(cyc, held);
    chk({nm, " busy_stall_held"}, {31'd0, held}, 32'd1);
    chk({nm, " latency"}, 32'(cyc), 32'(exp_lat(o, x, y)));
    chk({nm, " result"}, result, exp);
    chk({nm, " tag_out"}, {27'd0, tag_out}, {27'd0, t});
    chk({nm, " busy_at_done"}, {31'd0, busy}, 32'd0);
    step();
    chk({nm, " done_single"}, {31'd0, done}, 32'd0);
    last_res = exp;
    last_tag = t;
  endtask

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc, errs;
    bit  held, seen;
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    logic [4:0]  rt;

    vecs.push_back('{3'd0, 32'hFFFF_FFFF, 32'd5, 5'd9, 32'hFFFF_FFFB});
    vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'd5, 5'd9, 32'hFFFF_FFFF});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'd5, 5'd9, 32'h0000_0004});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'd5, 5'd10, 32'hFFFF_FFFF});
    vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd11, 32'h4000_0000});
    vecs.push_back('{3'd2, 32'h8000_0000, 32'h8000_0000, 5'd12, 32'hC000_0000});
    vecs.push_back('{3'd3, 32'h8000_0000, 32'h8000_0000, 5'd13, 32'h4000_0000});
    vecs.push_back('{3'd0, 32'h0001_0000, 32'h0001_0000, 5'd14, 32'h0000_0000});
    vecs.push_back('{3'd3, 32'h0001_0000, 32'h0001_0000, 5'd15, 32'h0000_0001});
    vecs.push_back('{3'd4, 32'hFFFF_FFEC, 32'd3, 5'd1, 32'hFFFF_FFFA});
    vecs.push_back('{3'd6, 32'hFFFF_FFEC, 32'd3, 5'd2, 32'hFFFF_FFFE});
    vecs.push_back('{3'd5, 32'd100, 32'd7, 5'd3, 32'd14});
    vecs.push_back('{3'd7, 32'd100, 32'd7, 5'd4, 32'd2});
    vecs.push_back('{3'd4, 32'd7, 32'hFFFF_FFFE, 5'd5, 32'hFFFF_FFFD});
    vecs.push_back('{3'd6, 32'd7, 32'hFFFF_FFFE, 5'd6, 32'd1});
    vecs.push_back('{3'd5, 32'h0000_1234, 32'd0, 5'd7, 32'hFFFF_FFFF});
    vecs.push_back('{3'd6, 32'h0000_1234, 32'd0, 5'd8, 32'h0000_1234});
    vecs.push_back('{3'd7, 32'h0000_1234, 32'd0, 5'd16, 32'h0000_1234});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd0, 5'd17, 32'hFFFF_FFFF});
    vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000});
    vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h0000_0000});

    // Reset held: start must be ignored
    rst = 1'b0; kill = 1'b0; start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd3; tag_in = 5'd1;
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) errs++;
    end
    chk("reset_hold_quiet", 32'(errs), 32'd0);
    start = 1'b0;
    rst   = 1'b1;
    step();
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_tag", {27'd0, tag_out}, 32'd0);
    last_res = 32'd0;
    last_tag = 5'd0;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].exp,
             $sformatf("vec%0d", i));
    end

    // kill during CALC of a DIV
    issue(3'd4, 32'd1000, 32'd7, 5'd20, "kill_calc");
    for (int i = 1; i < 10; i++) step();
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk("kill_calc busy", {31'd0, busy}, 32'd0);
    chk("kill_calc result_kept", result, last_res);
    chk("kill_calc tag_kept", {27'd0, tag_out}, {27'd0, last_tag});
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen = 1'b1;
      step();
    end
    chk("kill_calc no_done", {31'd0, seen}, 32'd0);

    // kill during FIN of a special-case divide
    issue(3'd5, 32'h55, 32'd0, 5'd21, "kill_fin");
    step();
    kill = 1'b1;
    step();
    kill = 1'b0;
    seen = done;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done) seen = 1'b1;
    end
    chk("kill_fin no_done", {31'd0, seen}, 32'd0);
    chk("kill_fin result_kept", result, last_res);

    // kill and start together in IDLE
    op = 3'd0; a = 32'd3; b = 32'd3; tag_in = 5'd22; start = 1'b1; kill = 1'b1;
    #1;
    chk("kill_start stall", {31'd0, stall_req}, 32'd0);
    step();
    start = 1'b0; kill = 1'b0;
    chk("kill_start busy", {31'd0, busy}, 32'd0);
    step();
    chk("kill_start done", {31'd0, done}, 32'd0);

    // start while busy is ignored
    issue(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd3, "busy_start");
    for (int i = 0; i < 4; i++) step();
    op = 3'd0; a = 32'd9; b = 32'd9; tag_in = 5'd30; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(cyc, held);
    chk("busy_start latency", 32'(cyc + 5), 32'd34);
    chk("busy_start result", result, 32'hFFFF_FFFA);
    chk("busy_start tag", {27'd0, tag_out}, 32'd3);
    last_res = 32'hFFFF_FFFA;
    last_tag = 5'd3;
    step();
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) seen = 1'b1;
      step();
    end
    chk("busy_start no_second", {31'd0, seen}, 32'd0);

    // Randomized operations against the reference model
    for (int n = 0; n < 200; n++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = $urandom;
      rt = 5'($urandom);
      case ($urandom_range(0, 9))
        0: ry = 32'd0;
        1: begin rx = 32'h8000_0000; ry = 32'hFFFF_FFFF; end
        2: ry = 32'($urandom_range(1, 15));
        3: ry = -32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(ro, rx, ry, rt, model(ro, rx, ry), $sformatf("rnd%0d", n));
    end

    // Reset in the middle of an operation
    issue(3'd5, 32'd500, 32'd9, 5'd25, "reset_mid");
    for (int i = 0; i < 5; i++) step();
    rst = 1'b0;
    #1;
    chk("reset_mid busy", {31'd0, busy}, 32'd0);
    chk("reset_mid result", result, 32'd0);
    step();
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen = 1'b1;
      step();
    end
    chk("reset_mid no_done", {31'd0, seen}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
